// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU for the execute stage. Single-cycle logic,
//            shift and compare ops complete in one cycle. mul, divu and remu
//            iterate one bit per cycle behind a start/ready/done handshake.
// Options  : SEQ_ALU_OVF_EN adds a registered 'overflow' output for
//            add, sub and mul.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   opCode,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] aluResult,
  output logic         zero
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic         overflow
`endif
);

  localparam int SH_W = $clog2(N);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // a_q : multiplicand (shifts left) / dividend that becomes the quotient
  // b_q : multiplier (shifts right)  / divisor
  // acc_q: product accumulator       / partial remainder
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       res_q, res_d;

`ifdef SEQ_ALU_OVF_EN
  logic               ovf_q, ovf_d;
  // mhi_q: a set bit has been shifted out of the multiplicand so far
  // movf_q: the partial product has already exceeded N bits
  logic               mhi_q, mhi_d;
  logic               movf_q, movf_d;
`endif

  // --------------------------------------------------------------------------
  // Single-cycle operation results, computed straight from the inputs
  // --------------------------------------------------------------------------
  logic [SH_W-1:0] w_sh;
  logic [N-1:0]    w_sum;
  logic [N-1:0]    w_diff;
  logic [N-1:0]    w_single_res;
  logic            w_is_iter;
  logic            w_single_ovf;

  // Combinational result of the one-cycle ops and the iterative-op decode
  always_comb begin
    w_sh         = srcB[SH_W-1:0];
    w_sum        = srcA + srcB;
    w_diff       = srcA - srcB;
    w_single_res = '0;
    w_single_ovf = 1'b0;
    w_is_iter    = (opCode == OP_MUL) || (opCode == OP_DIVU) || (opCode == OP_REMU);
    case (opCode)
      OP_ADD: begin
        w_single_res = w_sum;
        w_single_ovf = (srcA[N-1] == srcB[N-1]) && (w_sum[N-1] != srcA[N-1]);
      end
      OP_SUB: begin
        w_single_res = w_diff;
        w_single_ovf = (srcA[N-1] != srcB[N-1]) && (w_diff[N-1] != srcA[N-1]);
      end
      OP_AND:  w_single_res = srcA & srcB;
      OP_OR:   w_single_res = srcA | srcB;
      OP_XOR:  w_single_res = srcA ^ srcB;
      OP_SLT:  w_single_res = {{(N-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLTU: w_single_res = {{(N-1){1'b0}}, (srcA < srcB)};
      OP_SLL:  w_single_res = srcA << w_sh;
      OP_SRL:  w_single_res = srcA >> w_sh;
      OP_SRA:  w_single_res = $signed(srcA) >>> w_sh;
      default: w_single_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // One iteration step of shift-add multiply and restoring division
  // --------------------------------------------------------------------------
  logic [N-1:0] w_mul_acc;
  logic [N:0]   w_div_shift;
  logic [N:0]   w_div_trial;
  logic         w_div_ge;
  logic [N-1:0] w_div_rem;
  logic [N-1:0] w_div_quo;

  // Next partial product / partial remainder / quotient for this cycle
  always_comb begin
    w_mul_acc   = b_q[0] ? (acc_q + a_q) : acc_q;
    // Bring the next dividend bit (MSB first) into the remainder.
    w_div_shift = {acc_q, a_q[N-1]};
    w_div_trial = w_div_shift - {1'b0, b_q};
    // Full-width compare so a zero divisor always "fits": the quotient
    // becomes all ones and the remainder ends up equal to the dividend.
    w_div_ge    = (w_div_shift >= {1'b0, b_q});
    w_div_rem   = w_div_ge ? w_div_trial[N-1:0] : w_div_shift[N-1:0];
    w_div_quo   = {a_q[N-2:0], w_div_ge};
  end

`ifdef SEQ_ALU_OVF_EN
  logic [N:0] w_mul_wide;
  logic       w_movf_next;

  // The product exceeds N bits if any selected partial term was already
  // truncated, or if adding a term carries out of the accumulator.
  always_comb begin
    w_mul_wide  = {1'b0, acc_q} + {1'b0, a_q};
    w_movf_next = movf_q | (b_q[0] & (mhi_q | w_mul_wide[N]));
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  // FSM transitions plus operand latching, iteration and result write-back
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
`ifdef SEQ_ALU_OVF_EN
    ovf_d   = ovf_q;
    mhi_d   = mhi_q;
    movf_d  = movf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = opCode;
          a_d  = srcA;
          b_d  = srcB;
          if (w_is_iter) begin
            acc_d   = '0;
            cnt_d   = CNT_W'(N);
            state_d = S_BUSY;
`ifdef SEQ_ALU_OVF_EN
            mhi_d   = 1'b0;
            movf_d  = 1'b0;
`endif
          end else begin
            res_d   = w_single_res;
            state_d = S_DONE;
`ifdef SEQ_ALU_OVF_EN
            ovf_d   = w_single_ovf;
`endif
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = w_mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
`ifdef SEQ_ALU_OVF_EN
          mhi_d  = mhi_q | a_q[N-1];
          movf_d = w_movf_next;
`endif
        end else begin
          acc_d = w_div_rem;
          a_d   = w_div_quo;
        end
        // Last iteration: write the result straight from this step's output.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:  res_d = w_mul_acc;
            OP_DIVU: res_d = w_div_quo;
            default: res_d = w_div_rem;
          endcase
`ifdef SEQ_ALU_OVF_EN
          ovf_d = (op_q == OP_MUL) ? w_movf_next : 1'b0;
`endif
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous abort to the reset values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
`ifdef SEQ_ALU_OVF_EN
      ovf_q   <= 1'b0;
      mhi_q   <= 1'b0;
      movf_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
`ifdef SEQ_ALU_OVF_EN
      ovf_q   <= ovf_d;
      mhi_q   <= mhi_d;
      movf_q  <= movf_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // --------------------------------------------------------------------------
  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign aluResult = res_q;
  assign zero      = ~|res_q;
`ifdef SEQ_ALU_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Self-checking bench for seq_alu (N=32): directed vector table,
//            hand-written handshake/reset sequences and random operations
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

  localparam int N = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    opCode;
  logic [N-1:0]  srcA;
  logic [N-1:0]  srcB;
  logic          ready;
  logic          done;
  logic [N-1:0]  aluResult;
  logic          zero;
`ifdef SEQ_ALU_OVF_EN
  logic          overflow;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  seq_alu #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opCode    (opCode),
    .srcA      (srcA),
    .srcB      (srcB),
    .ready     (ready),
    .done      (done),
    .aluResult (aluResult),
    .zero      (zero)
`ifdef SEQ_ALU_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse, sampled mid-cycle.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    logic [63:0] prod;
    sh   = b % 32;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return 32'($signed(a) >>> sh);
      4'd10: return prod[31:0];
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint s;
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd10:  return prod[63:32] != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op == 4'd10 || op == 4'd11 || op == 4'd12) ? N + 1 : 1;
  endfunction

  // Issue one operation, scramble the inputs after acceptance, and wait
  // (bounded) for done. lat counts cycles from acceptance to done.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] res, output logic z, output logic ovf,
                     output int lat, output bit rdy_ok);
    rdy_ok = 1'b1;
    @(negedge clk);
    if (ready !== 1'b1) rdy_ok = 1'b0;
    start = 1'b1; opCode = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; opCode = 4'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (ready !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (ready !== 1'b0) rdy_ok = 1'b0;
    res = aluResult;
    z   = zero;
`ifdef SEQ_ALU_OVF_EN
    ovf = overflow;
`else
    ovf = 1'b0;
`endif
    @(posedge clk); #1;
    if (ready !== 1'b1 || done !== 1'b0) rdy_ok = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [31:0] res;
    logic z, ovf;
    int lat, d0, cyc;
    bit rdy_ok;

    tbl[0]  = '{4'd0,  32'd5,          32'hFFFF_FFFB, 32'd0,          1'b0};
    tbl[1]  = '{4'd5,  32'hFFFF_FFFF,  32'd1,         32'd1,          1'b0};
    tbl[2]  = '{4'd6,  32'hFFFF_FFFF,  32'd1,         32'd0,          1'b0};
    tbl[3]  = '{4'd9,  32'h8000_0000,  32'd4,         32'hF800_0000,  1'b0};
    tbl[4]  = '{4'd10, 32'd7,          32'd6,         32'd42,         1'b0};
    tbl[5]  = '{4'd11, 32'd100,        32'd7,         32'd14,         1'b0};
    tbl[6]  = '{4'd12, 32'd100,        32'd7,         32'd2,          1'b0};
    tbl[7]  = '{4'd11, 32'd5,          32'd0,         32'hFFFF_FFFF,  1'b0};
    tbl[8]  = '{4'd12, 32'd5,          32'd0,         32'd5,          1'b0};
    tbl[9]  = '{4'd1,  32'd3,          32'd5,         32'hFFFF_FFFE,  1'b0};
    tbl[10] = '{4'd4,  32'hF0F0_1234,  32'h0FF0_FFFF, 32'hFF00_EDCB,  1'b0};
    tbl[11] = '{4'd7,  32'd1,          32'd31,        32'h8000_0000,  1'b0};
    tbl[12] = '{4'd8,  32'h8000_0000,  32'd35,        32'h1000_0000,  1'b0};
    tbl[13] = '{4'd15, 32'd9,          32'd9,         32'd0,          1'b0};
    tbl[14] = '{4'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,          1'b1};
    tbl[15] = '{4'd0,  32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  1'b1};
    tbl[16] = '{4'd1,  32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  1'b1};
    tbl[17] = '{4'd10, 32'h0001_0000,  32'h0001_0000, 32'd0,          1'b1};

    rst = 1'b1; start = 1'b0; opCode = '0; srcA = '0; srcB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_result", aluResult, 0);
    chk("reset_zero", zero, 1);
`ifdef SEQ_ALU_OVF_EN
    chk("reset_ovf", overflow, 0);
`endif
    @(negedge clk); rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, res, z, ovf, lat, rdy_ok);
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_zero", i), z, (tbl[i].exp == 0));
      chk($sformatf("vec%0d_latency", i), lat, exp_lat(tbl[i].op));
      chk($sformatf("vec%0d_handshake", i), rdy_ok, 1);
`ifdef SEQ_ALU_OVF_EN
      chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
`endif
    end

    // start held high: mul then add, second accepted only after DONE
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; opCode = 4'd10; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1;
    opCode = 4'd0; srcA = 32'd10; srcB = 32'd20;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b2b_mul_cycles", cyc, N);
    chk("b2b_mul_result", aluResult, 15);
    @(posedge clk); #1;
    chk("b2b_idle_ready", ready, 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_add_done", done, 1);
    chk("b2b_add_result", aluResult, 30);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // Reset 10 cycles into a mul aborts without a done pulse
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; opCode = 4'd10; srcA = 32'd7; srcB = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("abort_ready", ready, 1);
    chk("abort_result", aluResult, 0);
    chk("abort_zero", zero, 1);
    @(negedge clk); rst = 1'b0;
    repeat (N + 5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rop;
      logic [31:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run(rop, ra, rb, res, z, ovf, lat, rdy_ok);
      chk($sformatf("rnd%0d_op%0d_result", i, rop), res, model(rop, ra, rb));
      chk($sformatf("rnd%0d_op%0d_latency", i, rop), lat, exp_lat(rop));
`ifdef SEQ_ALU_OVF_EN
      chk($sformatf("rnd%0d_op%0d_ovf", i, rop), ovf, model_ovf(rop, ra, rb));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU. Adds XOR, unsigned compare, shifts and iterative multiply, divide and remainder behind a start/done handshake. Sits in the execute stage of the multi-cycle core; the controller issues an operation and waits for done before consuming the result.

Parameters:
N, 32, operand/result width in bits (N >= 4).
CNT_W, $clog2(N)+1, width of the iteration counter.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; accepted only when ready=1.
opCode  input  4  operation select, sampled at acceptance.
srcA  input  N  operand A, sampled at acceptance.
srcB  input  N  operand B, sampled at acceptance.
ready  output  1  high in IDLE; block accepts start.
done  output  1  one-cycle pulse when aluResult becomes valid.
aluResult  output  N  registered result; held until the next accepted start completes.
zero  output  1  ~|aluResult, from the registered result.

Behaviour:
- Reset (async): state=IDLE, ready=1, done=0, aluResult=0, zero=1, counter and internal operand/accumulator registers=0.
- Opcodes: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor; 0101 slt signed (1/0); 0110 sltu; 0111 sll by srcB[$clog2(N)-1:0]; 1000 srl; 1001 sra; 1010 mul (low N bits of the product); 1011 divu (quotient); 1100 remu (remainder). Any other code returns 0 with single-cycle latency.
- All arithmetic is modulo 2^N. Carries and high product bits are discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if start=1, latch opCode/srcA/srcB.
  - Single-cycle op: aluResult is written at that edge; next state DONE.
  - mul/divu/remu: load the counter with N; next state BUSY.
- BUSY: one iteration per cycle.
  - mul: shift-add, LSB of the multiplier first.
  - divu/remu: restoring division, one quotient bit per cycle, MSB first.
  - When the counter reaches 0, aluResult is written; next state DONE.
- DONE: done=1 for exactly one cycle, ready=0; next state IDLE.
- Latency, with start accepted at edge t: single-cycle ops have done high in the cycle after t. mul/div/rem have done high N cycles later (N+1 cycles after acceptance).
- ready=0 in BUSY and DONE. start is ignored there, with no queueing. Back-to-back: a start in the first IDLE cycle after DONE is accepted.
- Divide by zero (srcB=0): divu returns all ones; remu returns srcA. Latency stays N+1 cycles.
- srcA/srcB/opCode changes after acceptance do not affect the in-flight operation.
- Reset asserted mid-operation aborts immediately to the reset values. No done pulse is issued for the aborted operation.
- aluResult and zero change only on completion edges or reset.

Optional Feature:
Macro SEQ_ALU_OVF_EN.
- Defined: adds output port overflow (1 bit), registered together with aluResult.
  - For add: set on signed overflow (operands share a sign and the result sign differs).
  - For sub: set when the operand signs differ and the result sign differs from srcA.
  - For mul: set when the unsigned product exceeds N bits.
  - 0 for all other ops. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then add with srcA=5, srcB=0xFFFFFFFB -> done one cycle after acceptance, aluResult=0, zero=1, ready back to 1 the following cycle.
2. slt with srcA=0xFFFFFFFF, srcB=1 -> aluResult=1. sltu with the same operands -> aluResult=0. sra with srcA=0x80000000, srcB=4 -> aluResult=0xF8000000.
3. mul with srcA=7, srcB=6 -> ready=0 for 32 cycles, done in cycle 33, aluResult=42. Operands changed during BUSY do not alter the result.
4. divu 100/7 -> aluResult=14. remu 100/7 -> aluResult=2. divu 5/0 -> aluResult=0xFFFFFFFF. remu 5/0 -> aluResult=5.
5. start held high continuously, issuing mul then add -> the second op is accepted only in the IDLE cycle after DONE; there are exactly two done pulses.
6. Assert rst 10 cycles into a mul -> immediately ready=1, aluResult=0, zero=1, and no done pulse. With SEQ_ALU_OVF_EN defined: add 0x7FFFFFFF+1 -> overflow=1, aluResult=0x80000000.
